// File: rtl/tournament_predictor.sv
// tournament_predictor: local/global tournament branch predictor with table-init sweep; BPRED_SPEC_GHIST_EN selects speculative global history
module tournament_predictor #(
    parameter int PC_W   = 10,
    parameter int LH_W   = 10,
    parameter int GH_W   = 12,
    parameter int LCTR_W = 3,
    parameter int GCTR_W = 2,
    parameter int CCTR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready_o,
    input  logic              pred_req_i,
    input  logic [PC_W-1:0]   pred_pc_i,
    output logic              pred_valid_o,
    output logic              pred_taken_o,
    output logic [LH_W-1:0]   pred_lhist_o,
    output logic [GH_W-1:0]   pred_ghist_o,
    input  logic              upd_valid_i,
    input  logic [PC_W-1:0]   upd_pc_i,
    input  logic [LH_W-1:0]   upd_lhist_i,
    input  logic [GH_W-1:0]   upd_ghist_i,
    input  logic              upd_taken_i,
    input  logic              upd_mispred_i
);
    localparam int IDX_W = (PC_W > LH_W) ? ((PC_W > GH_W) ? PC_W : GH_W)
                                         : ((LH_W > GH_W) ? LH_W : GH_W);
    localparam logic [LCTR_W-1:0] L_WNT = {1'b0, {(LCTR_W-1){1'b1}}};
    localparam logic [GCTR_W-1:0] G_WNT = {1'b0, {(GCTR_W-1){1'b1}}};
    localparam logic [CCTR_W-1:0] C_WLO = {1'b0, {(CCTR_W-1){1'b1}}};

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t             r_state, w_state_nxt;
    logic               w_run;
    logic [IDX_W-1:0]   r_idx;
    logic [LH_W-1:0]    r_lht  [2**PC_W];
    logic [LCTR_W-1:0]  r_lctr [2**LH_W];
    logic [GCTR_W-1:0]  r_gctr [2**GH_W];
    logic [CCTR_W-1:0]  r_cho  [2**GH_W];
    logic [GH_W-1:0]    r_ghist;
    logic               r_pred_valid, r_pred_taken;
    logic [LH_W-1:0]    r_pred_lhist;
    logic [GH_W-1:0]    r_pred_ghist;
    logic [LH_W-1:0]    w_lh;
    logic               w_pred;
    logic [LCTR_W-1:0]  w_ul, w_ul_nxt;
    logic [GCTR_W-1:0]  w_ug, w_ug_nxt;
    logic [CCTR_W-1:0]  w_uc, w_uc_nxt;
    logic               w_gcor, w_disagree;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_INIT;
        else        r_state <= w_state_nxt;
    end

    // next state: leave INIT on the edge that writes the last sweep index
    always_comb begin
        w_state_nxt = (r_state == S_INIT && &r_idx) ? S_RUN : r_state;
    end

    // state-decoded outputs
    always_comb begin
        w_run   = (r_state == S_RUN);
        ready_o = w_run;
    end

    // sweep index advances only while initialising
    always_ff @(posedge clk) begin
        if (!rst_n)      r_idx <= '0;
        else if (!w_run) r_idx <= r_idx + 1'b1;
    end

    // lookup path and saturating update arithmetic, all from pre-update table contents
    always_comb begin
        w_lh       = r_lht[pred_pc_i];
        w_pred     = r_cho[r_ghist][CCTR_W-1] ? r_gctr[r_ghist][GCTR_W-1] : r_lctr[w_lh][LCTR_W-1];
        w_ul       = r_lctr[upd_lhist_i];
        w_ug       = r_gctr[upd_ghist_i];
        w_uc       = r_cho[upd_ghist_i];
        w_ul_nxt   = upd_taken_i ? ((&w_ul) ? w_ul : w_ul + 1'b1) : ((|w_ul) ? w_ul - 1'b1 : w_ul);
        w_ug_nxt   = upd_taken_i ? ((&w_ug) ? w_ug : w_ug + 1'b1) : ((|w_ug) ? w_ug - 1'b1 : w_ug);
        w_gcor     = (w_ug[GCTR_W-1] == upd_taken_i);
        w_disagree = (w_ul[LCTR_W-1] != w_ug[GCTR_W-1]);
        w_uc_nxt   = !w_disagree ? w_uc
                   : w_gcor ? ((&w_uc) ? w_uc : w_uc + 1'b1) : ((|w_uc) ? w_uc - 1'b1 : w_uc);
    end

    // table writes: initial sweep, then resolved-branch training
    always_ff @(posedge clk) begin
        if (rst_n && !w_run) begin
            r_lht[r_idx[PC_W-1:0]]  <= '0;
            r_lctr[r_idx[LH_W-1:0]] <= L_WNT;
            r_gctr[r_idx[GH_W-1:0]] <= G_WNT;
            r_cho[r_idx[GH_W-1:0]]  <= C_WLO;
        end else if (rst_n && upd_valid_i) begin
            r_lctr[upd_lhist_i] <= w_ul_nxt;
            r_gctr[upd_ghist_i] <= w_ug_nxt;
            r_cho[upd_ghist_i]  <= w_uc_nxt;
            r_lht[upd_pc_i]     <= {r_lht[upd_pc_i][LH_W-2:0], upd_taken_i};
        end
    end

`ifdef BPRED_SPEC_GHIST_EN
    // speculative history: lookups shift in their prediction, a mispredict repairs from the snapshot
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_ghist <= '0;
        else if (w_run && upd_valid_i && upd_mispred_i)
            r_ghist <= {upd_ghist_i[GH_W-2:0], upd_taken_i};
        else if (w_run && pred_req_i)
            r_ghist <= {r_ghist[GH_W-2:0], w_pred};
    end
`else
    logic w_unused;
    assign w_unused = upd_mispred_i;

    // retired history: only resolved outcomes shift in
    always_ff @(posedge clk) begin
        if (!rst_n)                   r_ghist <= '0;
        else if (w_run && upd_valid_i) r_ghist <= {r_ghist[GH_W-2:0], upd_taken_i};
    end
`endif

    // registered lookup result, one cycle after the request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_lhist <= '0;
            r_pred_ghist <= '0;
        end else begin
            r_pred_valid <= w_run && pred_req_i;
            if (w_run && pred_req_i) begin
                r_pred_taken <= w_pred;
                r_pred_lhist <= w_lh;
                r_pred_ghist <= r_ghist;
            end
        end
    end

    assign pred_valid_o = r_pred_valid;
    assign pred_taken_o = r_pred_taken;
    assign pred_lhist_o = r_pred_lhist;
    assign pred_ghist_o = r_pred_ghist;
endmodule
